hypot_seq: RTL and testbench

- Sequencer that owns one square unit and one root unit and chains them to compute y = floor(sqrt(a^2 + b^2)).
- Replaces the ad-hoc bench-level sequencing with synthesizable control: unit start/reset pulsing, sum formation, overflow saturation, per-phase watchdog, and a single-shot result handshake to the client.

---
 rtl/hypot_seq.sv | 184 ++++++++++++++++++
 tb/tb_hypot_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hypot_seq.sv
// Chains a square unit and a root unit for y = floor(sqrt(a^2 + b^2)); latency = sq + rt unit latency + 4 cycles.
// No backpressure: start_i is taken only in IDLE and valid_o is a single-shot one-cycle pulse.
module hypot_seq #(
   parameter int TIMEOUT    = 64,
   parameter int CLR_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] a_bi,
   input  logic [31:0] b_bi,
   output logic        busy_o,
   output logic        valid_o,
   output logic [31:0] y_bo,
   output logic        ovf_o,
   output logic        err_o,
   output logic [2:0]  state_o,
   output logic        sq_rst_o,
   output logic        sq_start_o,
   output logic [31:0] sq_a_bo,
   output logic [31:0] sq_b_bo,
   input  logic [2:0]  sq_state_bi,
   input  logic [63:0] sq_y_a_bi,
   input  logic [63:0] sq_y_b_bi,
   output logic        rt_rst_o,
   output logic        rt_start_o,
   output logic [31:0] rt_x_bo,
   input  logic [2:0]  rt_state_bi,
   input  logic [31:0] rt_y_bi
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SQ   = 3'd1,
      S_RT   = 3'd2,
      S_DONE = 3'd3,
      S_CLR  = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   localparam logic [2:0] U_IDLE  = 3'd0;
   localparam logic [2:0] U_DONE  = 3'd2;
   localparam int         CNT_MAX = (TIMEOUT > CLR_CYCLES) ? TIMEOUT : CLR_CYCLES;
   localparam int         CW      = $clog2(CNT_MAX + 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_d, valid_d, ovf_d, err_d;
   logic          sq_rst_d, sq_start_d, rt_rst_d, rt_start_d;
   logic [31:0]   y_d, sq_a_d, sq_b_d, rt_x_d;
   logic [64:0]   sum;
   logic          sq_done, rt_done, wd_hit, clr_last;

   // 65-bit sum so the carry out of two full-range squares is never lost
   assign sum      = {1'b0, sq_y_a_bi} + {1'b0, sq_y_b_bi};
   assign sq_done  = (sq_state_bi == U_DONE);
   assign rt_done  = (rt_state_bi == U_DONE);
   assign wd_hit   = (cnt_q == CW'(TIMEOUT - 1));
   assign clr_last = (cnt_q == CW'(CLR_CYCLES - 1));
   assign state_o  = state_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      valid_d    = 1'b0;
      ovf_d      = ovf_o;
      err_d      = err_o;
      y_d        = y_bo;
      sq_a_d     = sq_a_bo;
      sq_b_d     = sq_b_bo;
      rt_x_d     = rt_x_bo;
      sq_rst_d   = sq_rst_o;
      rt_rst_d   = rt_rst_o;
      sq_start_d = sq_start_o;
      rt_start_d = rt_start_o;

      case (state_q)
         S_IDLE: begin
            sq_rst_d = 1'b0;
            rt_rst_d = 1'b0;
            if (start_i) begin
               sq_a_d     = a_bi;
               sq_b_d     = b_bi;
               ovf_d      = 1'b0;
               err_d      = 1'b0;
               y_d        = '0;
               sq_start_d = 1'b1;
               state_d    = S_SQ;
            end
         end
         S_SQ: begin
            // completion is tested before the watchdog so a late done still wins
            if (sq_done) begin
               sq_start_d = 1'b0;
               ovf_d      = |sum[64:32];
               rt_x_d     = (|sum[64:32]) ? 32'hFFFF_FFFF : sum[31:0];
               rt_start_d = 1'b1;
               state_d    = S_RT;
            end else if (wd_hit) begin
               sq_start_d = 1'b0;
               rt_start_d = 1'b0;
               err_d      = 1'b1;
               state_d    = S_ERR;
            end else begin
               sq_start_d = (sq_state_bi == U_IDLE);
               cnt_d      = cnt_q + 1'b1;
            end
         end
         S_RT: begin
            if (rt_done) begin
               rt_start_d = 1'b0;
               y_d        = rt_y_bi;
               valid_d    = 1'b1;
               state_d    = S_DONE;
            end else if (wd_hit) begin
               sq_start_d = 1'b0;
               rt_start_d = 1'b0;
               err_d      = 1'b1;
               state_d    = S_ERR;
            end else begin
               rt_start_d = (rt_state_bi == U_IDLE);
               cnt_d      = cnt_q + 1'b1;
            end
         end
         S_DONE, S_ERR: begin
            sq_rst_d = 1'b1;
            rt_rst_d = 1'b1;
            state_d  = S_CLR;
         end
         S_CLR: begin
            if (clr_last) begin
               sq_rst_d = 1'b0;
               rt_rst_d = 1'b0;
               state_d  = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         busy_o     <= 1'b0;
         valid_o    <= 1'b0;
         y_bo       <= '0;
         ovf_o      <= 1'b0;
         err_o      <= 1'b0;
         sq_rst_o   <= 1'b1;
         sq_start_o <= 1'b0;
         sq_a_bo    <= '0;
         sq_b_bo    <= '0;
         rt_rst_o   <= 1'b1;
         rt_start_o <= 1'b0;
         rt_x_bo    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_o     <= busy_d;
         valid_o    <= valid_d;
         y_bo       <= y_d;
         ovf_o      <= ovf_d;
         err_o      <= err_d;
         sq_rst_o   <= sq_rst_d;
         sq_start_o <= sq_start_d;
         sq_a_bo    <= sq_a_d;
         sq_b_bo    <= sq_b_d;
         rt_rst_o   <= rt_rst_d;
         rt_start_o <= rt_start_d;
         rt_x_bo    <= rt_x_d;
      end
   end

endmodule

// File: tb/tb_hypot_seq.sv
// Bench for hypot_seq with behavioural square/root unit stubs and a scoreboard of expected results.
module tb_hypot_seq;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_SQ   = 3'd1;
   localparam logic [2:0] ST_RT   = 3'd2;
   localparam logic [2:0] ST_CLR  = 3'd4;
   localparam logic [2:0] ST_ERR  = 3'd5;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [31:0] a_bi = '0;
   logic [31:0] b_bi = '0;
   logic        busy_o, valid_o, ovf_o, err_o;
   logic [31:0] y_bo;
   logic [2:0]  state_o;
   logic        sq_rst_o, sq_start_o, rt_rst_o, rt_start_o;
   logic [31:0] sq_a_bo, sq_b_bo, rt_x_bo;
   logic [2:0]  sq_state_bi = 3'd0;
   logic [63:0] sq_y_a_bi = '0;
   logic [63:0] sq_y_b_bi = '0;
   logic [2:0]  rt_state_bi = 3'd0;
   logic [31:0] rt_y_bi = '0;

   typedef struct {
      logic [31:0] y;
      logic        ovf;
      logic [31:0] x;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   vectors = 0;
   int   miscompares = 0;
   int   n_valid = 0;
   logic prev_valid = 1'b0;
   int   sq_lat = 3;
   int   rt_lat = 4;
   logic sq_stuck = 1'b0;
   int   sq_cnt = 0;
   int   rt_cnt = 0;

   always #5 clk_i = ~clk_i;

   hypot_seq #(.TIMEOUT(64), .CLR_CYCLES(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .a_bi(a_bi), .b_bi(b_bi),
      .busy_o(busy_o), .valid_o(valid_o), .y_bo(y_bo), .ovf_o(ovf_o), .err_o(err_o),
      .state_o(state_o), .sq_rst_o(sq_rst_o), .sq_start_o(sq_start_o),
      .sq_a_bo(sq_a_bo), .sq_b_bo(sq_b_bo), .sq_state_bi(sq_state_bi),
      .sq_y_a_bi(sq_y_a_bi), .sq_y_b_bi(sq_y_b_bi), .rt_rst_o(rt_rst_o),
      .rt_start_o(rt_start_o), .rt_x_bo(rt_x_bo), .rt_state_bi(rt_state_bi),
      .rt_y_bi(rt_y_bi)
   );

   function automatic logic [31:0] isqrt(input logic [31:0] x);
      logic [31:0] r, t;
      r = '0;
      for (int i = 15; i >= 0; i--) begin
         t = r | (32'd1 << i);
         if ({32'd0, t} * {32'd0, t} <= {32'd0, x}) r = t;
      end
      return r;
   endfunction

   // square unit stub: idle -> busy for sq_lat cycles -> done until reset
   always @(posedge clk_i) begin
      if (sq_rst_o === 1'b1) begin
         sq_state_bi <= 3'd0;
      end else if (sq_state_bi == 3'd0) begin
         if (sq_start_o === 1'b1) begin
            sq_state_bi <= 3'd1;
            sq_cnt      <= sq_lat;
            sq_y_a_bi   <= {32'd0, sq_a_bo} * {32'd0, sq_a_bo};
            sq_y_b_bi   <= {32'd0, sq_b_bo} * {32'd0, sq_b_bo};
         end
      end else if (sq_state_bi == 3'd1 && !sq_stuck) begin
         if (sq_cnt <= 1) sq_state_bi <= 3'd2;
         else sq_cnt <= sq_cnt - 1;
      end
   end

   // root unit stub
   always @(posedge clk_i) begin
      if (rt_rst_o === 1'b1) begin
         rt_state_bi <= 3'd0;
      end else if (rt_state_bi == 3'd0) begin
         if (rt_start_o === 1'b1) begin
            rt_state_bi <= 3'd1;
            rt_cnt      <= rt_lat;
            rt_y_bi     <= isqrt(rt_x_bo);
         end
      end else if (rt_state_bi == 3'd1) begin
         if (rt_cnt <= 1) rt_state_bi <= 3'd2;
         else rt_cnt <= rt_cnt - 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk_i) begin
      if (valid_o === 1'b1) begin
         n_valid++;
         chk("valid_expected", 64'(exp_q.size() != 0), 64'd1);
         chk("valid_one_cycle", 64'(prev_valid), 64'd0);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("y", 64'(y_bo), 64'(e.y));
            chk("ovf", 64'(ovf_o), 64'(e.ovf));
            chk("err_on_valid", 64'(err_o), 64'd0);
            chk("rt_x", 64'(rt_x_bo), 64'(e.x));
         end
      end
      prev_valid = valid_o;
   end

   task automatic wait_state(input string tag, input logic [2:0] st, input int lim);
      int k;
      k = 0;
      do begin
         @(negedge clk_i);
         k++;
      end while (state_o !== st && k < lim);
      chk(tag, 64'(state_o), 64'(st));
   endtask

   task automatic wait_valid(input string tag, input int lim);
      int k;
      k = 0;
      do begin
         @(negedge clk_i);
         k++;
      end while (valid_o !== 1'b1 && k < lim);
      chk(tag, 64'(valid_o), 64'd1);
   endtask

   task automatic start_job(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk_i);
      a_bi    = a;
      b_bi    = b;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic run_job(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] y, input logic ovf, input logic [31:0] x);
      exp_q.push_back('{y: y, ovf: ovf, x: x});
      start_job(a, b);
      wait_valid("job_valid", 300);
      wait_state("job_idle", ST_IDLE, 20);
      chk("y_hold", 64'(y_bo), 64'(y));
   endtask

   initial begin
      int n, nv;
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      chk("rst_state", 64'(state_o), 64'(ST_IDLE));
      chk("rst_unit_resets", 64'({sq_rst_o, rt_rst_o}), 64'd3);
      chk("rst_flags", 64'({busy_o, valid_o, ovf_o, err_o, sq_start_o, rt_start_o}), 64'd0);
      chk("rst_data", 64'(y_bo | sq_a_bo | sq_b_bo | rt_x_bo), 64'd0);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("idle_unit_resets", 64'({sq_rst_o, rt_rst_o}), 64'd0);

      // 3,4 -> 5 with a closer look at DONE -> CLR -> IDLE
      exp_q.push_back('{y: 32'd5, ovf: 1'b0, x: 32'd25});
      start_job(32'd3, 32'd4);
      chk("sq_entry", 64'({state_o, busy_o, sq_start_o}), 64'({ST_SQ, 1'b1, 1'b1}));
      wait_valid("valid_3_4", 300);
      @(negedge clk_i);
      chk("clr1", 64'({state_o, sq_rst_o, rt_rst_o, valid_o}), 64'({ST_CLR, 3'b110}));
      @(negedge clk_i);
      chk("clr2", 64'({state_o, sq_rst_o, rt_rst_o}), 64'({ST_CLR, 2'b11}));
      @(negedge clk_i);
      chk("clr_exit", 64'({state_o, sq_rst_o, rt_rst_o, busy_o}), 64'({ST_IDLE, 3'b000}));
      chk("y_after_3_4", 64'(y_bo), 64'd5);

      run_job(32'd255, 32'd255, 32'd360, 1'b0, 32'd130050);
      run_job(32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
      run_job(32'h0001_0000, 32'h0001_0000, 32'd65535, 1'b1, 32'hFFFF_FFFF);
      chk("ovf_hold", 64'(ovf_o), 64'd1);

      // watchdog: square unit never completes
      sq_stuck = 1'b1;
      nv = n_valid;
      start_job(32'd7, 32'd9);
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (err_o !== 1'b1 && n < 200);
      chk("wd_cycles", 64'(n), 64'd64);
      chk("wd_err_state", 64'(state_o), 64'(ST_ERR));
      wait_state("wd_idle", ST_IDLE, 20);
      chk("wd_err_sticky", 64'({err_o, valid_o}), 64'd2);
      chk("wd_y_zero", 64'(y_bo), 64'd0);
      chk("wd_no_valid", 64'(n_valid), 64'(nv));
      sq_stuck = 1'b0;
      run_job(32'd3, 32'd4, 32'd5, 1'b0, 32'd25);
      chk("err_cleared", 64'(err_o), 64'd0);

      // start and operand changes during RT are ignored
      rt_lat = 10;
      exp_q.push_back('{y: 32'd10, ovf: 1'b0, x: 32'd100});
      start_job(32'd6, 32'd8);
      wait_state("ign_rt", ST_RT, 50);
      a_bi    = 32'd99;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      chk("ign_operand", 64'(sq_a_bo), 64'd6);
      wait_valid("ign_valid", 300);
      wait_state("ign_idle", ST_IDLE, 20);
      rt_lat = 4;

      // start held high gives two back-to-back jobs
      nv = n_valid;
      exp_q.push_back('{y: 32'd13, ovf: 1'b0, x: 32'd169});
      exp_q.push_back('{y: 32'd13, ovf: 1'b0, x: 32'd169});
      @(negedge clk_i);
      a_bi    = 32'd5;
      b_bi    = 32'd12;
      start_i = 1'b1;
      wait_valid("b2b_first", 300);
      wait_valid("b2b_second", 300);
      start_i = 1'b0;
      wait_state("b2b_idle", ST_IDLE, 20);
      repeat (4) @(negedge clk_i);
      chk("b2b_count", 64'(n_valid - nv), 64'd2);
      chk("b2b_queue", 64'(exp_q.size()), 64'd0);

      // asynchronous reset in the middle of RT
      rt_lat = 10;
      nv = n_valid;
      start_job(32'd3, 32'd4);
      wait_state("rst_rt", ST_RT, 50);
      #2 rst_i = 1'b0;
      #1;
      chk("arst_state", 64'(state_o), 64'(ST_IDLE));
      chk("arst_units", 64'({sq_rst_o, rt_rst_o, busy_o, valid_o}), 64'b1100);
      @(negedge clk_i);
      rst_i = 1'b1;
      repeat (20) @(negedge clk_i);
      chk("arst_no_valid", 64'(n_valid), 64'(nv));
      chk("arst_idle", 64'({state_o, sq_rst_o, rt_rst_o}), 64'({ST_IDLE, 2'b00}));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench timeout");
   end

endmodule
